ibex_wb_queue_stage: RTL

IBEX_WB_QUEUE_STAGE -- requirements
Module: ibex_wb_queue_stage

---
 rtl/ibex_wb_queue_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ibex_wb_queue_stage.sv
// ibex_wb_queue_stage: multi-entry in-order writeback queue with a one-entry LSU response buffer.
// LOAD/STORE entries retire on their response; OTHER entries retire as soon as they reach the head.
module ibex_wb_queue_stage #(
    parameter int unsigned WbDepth  = 2,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_wb_i,
    input  logic [1:0]                   instr_type_wb_i,
    input  logic [31:0]                  pc_id_i,
    input  logic                         instr_is_compressed_id_i,
    input  logic                         instr_perf_count_id_i,
    input  logic [4:0]                   rf_waddr_id_i,
    input  logic [31:0]                  rf_wdata_id_i,
    input  logic                         rf_we_int_id_i,
    input  logic                         rf_we_fp_id_i,
    input  logic                         rf_lsu_to_fp_i,
    input  logic [31:0]                  rf_wdata_lsu_i,
    input  logic                         lsu_resp_valid_i,
    input  logic                         lsu_resp_err_i,
    output logic                         ready_wb_o,
    output logic [$clog2(WbDepth+1)-1:0] wb_count_o,
    output logic                         rf_write_wb_o,
    output logic                         outstanding_load_wb_o,
    output logic                         outstanding_store_wb_o,
    output logic [31:0]                  pc_wb_o,
    output logic                         instr_done_wb_o,
    output logic                         perf_instr_ret_wb_o,
    output logic                         perf_instr_ret_compressed_wb_o,
    output logic [4:0]                   rf_waddr_wb_o,
    output logic [31:0]                  rf_wdata_wb_o,
    output logic                         rf_we_int_wb_o,
    output logic                         rf_we_fp_wb_o,
    output logic [31:0]                  rf_wdata_fwd_wb_o
);
    localparam int PtrW = (WbDepth > 1) ? $clog2(WbDepth) : 1;
    localparam int CntW = $clog2(WbDepth + 1);

    typedef enum logic [1:0] {WB_INSTR_LOAD, WB_INSTR_STORE, WB_INSTR_OTHER} wb_instr_type_e;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we_int;
        logic        we_fp;
        logic        lsu_to_fp;
        logic [31:0] pc;
        logic        compressed;
        logic        count;
    } entry_t;

    entry_t             mem_q [WbDepth];
    entry_t             mem_d [WbDepth];
    entry_t             new_e;
    entry_t             head;
    logic [WbDepth-1:0] valid_q, valid_d;
    logic [PtrW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               rbuf_valid_q, rbuf_valid_d, rbuf_err_q, rbuf_err_d;
    logic [31:0]        rbuf_data_q, rbuf_data_d;
    logic               head_valid, head_mem, head_load, resp_err, enq, capture, consume, load_ok;
    logic [31:0]        resp_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(WbDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign new_e = '{typ: instr_type_wb_i, waddr: rf_waddr_id_i, wdata: rf_wdata_id_i,
                     we_int: rf_we_int_id_i, we_fp: rf_we_fp_id_i, lsu_to_fp: rf_lsu_to_fp_i,
                     pc: pc_id_i, compressed: instr_is_compressed_id_i, count: instr_perf_count_id_i};

    assign head       = mem_q[head_q];
    assign head_valid = (count_q != '0);
    assign head_mem   = head_valid & (head.typ != WB_INSTR_OTHER);
    assign head_load  = head_valid & (head.typ == WB_INSTR_LOAD);
    // The buffered response is older than any direct one, so it always wins.
    assign resp_data  = rbuf_valid_q ? rbuf_data_q : rf_wdata_lsu_i;
    assign resp_err   = rbuf_valid_q ? rbuf_err_q : lsu_resp_err_i;
    assign load_ok    = head_load & ~resp_err;

    assign instr_done_wb_o = head_valid & (~head_mem | rbuf_valid_q | lsu_resp_valid_i);
    assign ready_wb_o      = (count_q != CntW'(WbDepth)) | instr_done_wb_o;
    assign enq             = en_wb_i & ready_wb_o;
    assign consume         = instr_done_wb_o & head_mem & rbuf_valid_q;
    assign capture         = lsu_resp_valid_i & (~head_mem | rbuf_valid_q);

    assign wb_count_o        = count_q;
    assign pc_wb_o           = head_valid ? head.pc : '0;
    assign rf_waddr_wb_o     = head_valid ? head.waddr : '0;
    assign rf_wdata_fwd_wb_o = head_valid ? head.wdata : '0;
    assign rf_wdata_wb_o     = instr_done_wb_o ? (head_load ? resp_data : head.wdata) : '0;
    assign rf_we_int_wb_o    = instr_done_wb_o & (head_mem ? load_ok & ~head.lsu_to_fp : head.we_int);
    assign rf_we_fp_wb_o     = instr_done_wb_o & (head_mem ? load_ok & head.lsu_to_fp : head.we_fp);
    assign perf_instr_ret_wb_o            = instr_done_wb_o & head.count & ~(head_mem & resp_err);
    assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o & head.compressed;

    always_comb begin
        rf_write_wb_o          = 1'b0;
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        for (int i = 0; i < WbDepth; i++) begin
            rf_write_wb_o          |= valid_q[i] & (mem_q[i].we_int | mem_q[i].we_fp | (mem_q[i].typ == WB_INSTR_LOAD));
            outstanding_load_wb_o  |= valid_q[i] & (mem_q[i].typ == WB_INSTR_LOAD);
            outstanding_store_wb_o |= valid_q[i] & (mem_q[i].typ == WB_INSTR_STORE);
        end
    end

    always_comb begin
        mem_d        = mem_q;
        valid_d      = valid_q;
        head_d       = instr_done_wb_o ? ptr_inc(head_q) : head_q;
        tail_d       = enq ? ptr_inc(tail_q) : tail_q;
        count_d      = count_q + CntW'(enq) - CntW'(instr_done_wb_o);
        rbuf_valid_d = capture | (rbuf_valid_q & ~consume);
        rbuf_data_d  = capture ? rf_wdata_lsu_i : rbuf_data_q;
        rbuf_err_d   = capture ? lsu_resp_err_i : rbuf_err_q;
        if (instr_done_wb_o) valid_d[head_q] = 1'b0;
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            mem_d[tail_q]   = new_e;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rbuf_valid_q <= 1'b0;
            rbuf_err_q   <= 1'b0;
            rbuf_data_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rbuf_valid_q <= rbuf_valid_d;
            rbuf_err_q   <= rbuf_err_d;
            rbuf_data_q  <= rbuf_data_d;
        end
    end

    if (ResetAll) begin : g_payload_rst
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) mem_q <= '{default: '0};
            else         mem_q <= mem_d;
        end
    end else begin : g_payload_nrst
        always_ff @(posedge clk_i) begin
            mem_q <= mem_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) en_wb_i |-> ready_wb_o);
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(lsu_resp_valid_i & rbuf_valid_q & ~consume));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(rf_we_int_wb_o & rf_we_fp_wb_o));
endmodule
